// File: rtl/usbf_ep_pkg.sv
// rtl/usbf_ep_pkg.sv - shared constants for the USB IN-endpoint transmit scheduler
// Contents: FSM state encodings (3-bit), default maximum packet size, PID select values.
package usbf_ep_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RESP    = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_STREAM  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_WAIT_HS = 3'd5;

  localparam int MAX_PKT_DEF = 64;

  localparam logic PID_DATA0 = 1'b0;
  localparam logic PID_DATA1 = 1'b1;

endpackage

// File: rtl/usbf_ep_toggle.sv
// rtl/usbf_ep_toggle.sv - per-endpoint DATA0/DATA1 toggle and zero-length-packet pending bits
// Ports: clk_i/rst_i (async active-low) clock and reset; flip_i flips toggle of ep_i;
//        clr_i per-endpoint force to DATA0 (wins over flip, also drops zlp_pend);
//        zlp_set_i/zlp_clr_i set/clear zlp_pend of ep_i; toggle_o, zlp_pend_o state.
// Optional macro USBF_TX_ZLP_EN: when undefined there is no zlp_pend storage.
module usbf_ep_toggle
  import usbf_ep_pkg::*;
#(
  parameter int EP_NUM = 4,
  parameter int EP_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flip_i,
  input  logic [EP_W-1:0]   ep_i,
  input  logic [EP_NUM-1:0] clr_i,
  input  logic              zlp_set_i,
  input  logic              zlp_clr_i,
  output logic [EP_NUM-1:0] toggle_o,
  output logic [EP_NUM-1:0] zlp_pend_o
);

  logic [EP_NUM-1:0] toggle_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      toggle_q <= {EP_NUM{PID_DATA0}};
    end else begin
      for (int i = 0; i < EP_NUM; i++) begin
        if (clr_i[i])
          toggle_q[i] <= PID_DATA0;
        else if (flip_i && (ep_i == EP_W'(i)))
          toggle_q[i] <= ~toggle_q[i];
      end
    end
  end

  assign toggle_o = toggle_q;

`ifdef USBF_TX_ZLP_EN
  logic [EP_NUM-1:0] zlp_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      zlp_q <= '0;
    end else begin
      for (int i = 0; i < EP_NUM; i++) begin
        if (clr_i[i] || (zlp_clr_i && (ep_i == EP_W'(i))))
          zlp_q[i] <= 1'b0;
        else if (zlp_set_i && (ep_i == EP_W'(i)))
          zlp_q[i] <= 1'b1;
      end
    end
  end

  assign zlp_pend_o = zlp_q;
`else
  logic zlp_unused;
  assign zlp_unused = zlp_set_i ^ zlp_clr_i;
  assign zlp_pend_o = '0;
`endif

endmodule

// File: rtl/usbf_ep_tx_sched.sv
// rtl/usbf_ep_tx_sched.sv - token-directed IN-transfer scheduler between endpoint TX FIFOs and the SIE
// Ports: clk_i/rst_i (async active-low); token_valid_i/token_ep_i IN token; ep_stall_i halt;
//        toggle_clr_i force DATA0; fifo_empty_i/fifo_data_i/fifo_pop_o FIFO heads;
//        tx_valid_o/tx_data_o/tx_accept_i payload handshake; tx_start_o/tx_data1_o/tx_end_o
//        packet framing; tx_nak_o/tx_stall_o handshake requests; rx_ack_i/rx_timeout_i host
//        handshake result; busy_o scheduler active.
// Optional macro USBF_TX_ZLP_EN: send a zero-length packet after a full packet drains the FIFO.
module usbf_ep_tx_sched
  import usbf_ep_pkg::*;
#(
  parameter int EP_NUM  = 4,
  parameter int EP_W    = 2,
  parameter int MAX_PKT = MAX_PKT_DEF,
  parameter int CNT_W   = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                token_valid_i,
  input  logic [EP_W-1:0]     token_ep_i,
  input  logic [EP_NUM-1:0]   ep_stall_i,
  input  logic [EP_NUM-1:0]   toggle_clr_i,
  input  logic [EP_NUM-1:0]   fifo_empty_i,
  input  logic [8*EP_NUM-1:0] fifo_data_i,
  output logic [EP_NUM-1:0]   fifo_pop_o,
  output logic                tx_valid_o,
  output logic [7:0]          tx_data_o,
  input  logic                tx_accept_i,
  output logic                tx_start_o,
  output logic                tx_data1_o,
  output logic                tx_end_o,
  output logic                tx_nak_o,
  output logic                tx_stall_o,
  input  logic                rx_ack_i,
  input  logic                rx_timeout_i,
  output logic                busy_o
);

  logic [2:0]        state;
  logic [EP_W-1:0]   ep_q;
  logic [CNT_W-1:0]  byte_cnt;
  logic              pid_q;
  logic              nak_q;
  logic              stall_q;
  logic              zlp_q;    // packet in flight is a zero-length packet
  logic              full_q;   // packet in flight ended full with its FIFO drained
  logic [EP_NUM-1:0] toggle;
  logic [EP_NUM-1:0] zlp_pend;

  logic in_stream;
  logic ep_empty;
  logic ep_stall;
  logic pop;
  logic full_cond;
  logic flip;
  logic zlp_set;
  logic zlp_clr;

  assign in_stream = (state == ST_STREAM);
  assign ep_empty  = fifo_empty_i[ep_q];
  assign ep_stall  = ep_stall_i[ep_q];

  assign tx_valid_o = in_stream & ~ep_empty & (byte_cnt < CNT_W'(MAX_PKT));
  assign tx_data_o  = in_stream ? fifo_data_i[{ep_q, 3'b000} +: 8] : 8'h00;
  assign pop        = tx_valid_o & tx_accept_i;
  assign fifo_pop_o = pop ? (EP_NUM'(1) << ep_q) : '0;

  assign tx_start_o = (state == ST_START);
  assign tx_end_o   = (state == ST_DONE);
  assign tx_data1_o = ((state == ST_START) || in_stream || (state == ST_DONE)) ? pid_q : 1'b0;
  assign tx_nak_o   = nak_q;
  assign tx_stall_o = stall_q;
  assign busy_o     = (state != ST_IDLE);

  assign full_cond = (byte_cnt == CNT_W'(MAX_PKT)) & ep_empty;
  assign flip      = (state == ST_WAIT_HS) & rx_ack_i;
  assign zlp_set   = (state == ST_DONE) & full_cond;
  // An ACK clears a stale pending ZLP, but not the one the acknowledged packet itself requested.
  assign zlp_clr   = ((state == ST_DONE) & zlp_q) | (flip & ~full_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      ep_q     <= '0;
      byte_cnt <= '0;
      pid_q    <= PID_DATA0;
      nak_q    <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      nak_q   <= 1'b0;
      stall_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (token_valid_i) begin
            ep_q  <= token_ep_i;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (ep_stall) begin
            stall_q <= 1'b1;
            state   <= ST_IDLE;
          end else if (ep_empty && !zlp_pend[ep_q]) begin
            nak_q <= 1'b1;
            state <= ST_IDLE;
          end else begin
            pid_q <= toggle[ep_q];
            state <= ST_START;
          end
        end
        ST_START: begin
          byte_cnt <= '0;
          if (rx_timeout_i)
            state <= ST_IDLE;
          else
            state <= zlp_q ? ST_DONE : ST_STREAM;
        end
        ST_STREAM: begin
          if (rx_timeout_i)
            state <= ST_IDLE;
          else if (!tx_valid_o)
            state <= ST_DONE;
          else if (pop)
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          state <= ST_WAIT_HS;
        end
        ST_WAIT_HS: begin
          if (rx_ack_i || rx_timeout_i)
            state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef USBF_TX_ZLP_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      zlp_q  <= 1'b0;
      full_q <= 1'b0;
    end else begin
      if (state == ST_RESP)
        zlp_q <= ep_empty & zlp_pend[ep_q];
      if (state == ST_DONE)
        full_q <= full_cond;
    end
  end
`else
  assign zlp_q  = 1'b0;
  assign full_q = 1'b0;
`endif

  usbf_ep_toggle #(
    .EP_NUM (EP_NUM),
    .EP_W   (EP_W)
  ) u_toggle (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flip_i     (flip),
    .ep_i       (ep_q),
    .clr_i      (toggle_clr_i),
    .zlp_set_i  (zlp_set),
    .zlp_clr_i  (zlp_clr),
    .toggle_o   (toggle),
    .zlp_pend_o (zlp_pend)
  );

endmodule

// File: tb/tb_usbf_ep_tx_sched.sv
// tb/tb_usbf_ep_tx_sched.sv - self-checking bench for usbf_ep_tx_sched
module tb_usbf_ep_tx_sched;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        token_valid_i = 1'b0;
  logic [1:0]  token_ep_i = '0;
  logic [3:0]  ep_stall_i = '0;
  logic [3:0]  toggle_clr_i = '0;
  logic [3:0]  fifo_empty_i;
  logic [31:0] fifo_data_i;
  logic [3:0]  fifo_pop_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_accept_i = 1'b0;
  logic        tx_start_o;
  logic        tx_data1_o;
  logic        tx_end_o;
  logic        tx_nak_o;
  logic        tx_stall_o;
  logic        rx_ack_i = 1'b0;
  logic        rx_timeout_i = 1'b0;
  logic        busy_o;

  usbf_ep_tx_sched dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .token_valid_i (token_valid_i),
    .token_ep_i    (token_ep_i),
    .ep_stall_i    (ep_stall_i),
    .toggle_clr_i  (toggle_clr_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_data_i   (fifo_data_i),
    .fifo_pop_o    (fifo_pop_o),
    .tx_valid_o    (tx_valid_o),
    .tx_data_o     (tx_data_o),
    .tx_accept_i   (tx_accept_i),
    .tx_start_o    (tx_start_o),
    .tx_data1_o    (tx_data1_o),
    .tx_end_o      (tx_end_o),
    .tx_nak_o      (tx_nak_o),
    .tx_stall_o    (tx_stall_o),
    .rx_ack_i      (rx_ack_i),
    .rx_timeout_i  (rx_timeout_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: mem/wr written by the test, rd only by the pop process.
  logic [7:0] mem [4][256];
  int         wr [4];
  int         rd [4];
  logic [3:0] flush_req = '0;
  logic [3:0] pop_s = '0;
  int         pop_cnt [4];

  always_comb begin
    fifo_empty_i = '0;
    fifo_data_i  = '0;
    for (int i = 0; i < 4; i++) begin
      fifo_empty_i[i]       = (rd[i] == wr[i]);
      fifo_data_i[8*i +: 8] = mem[i][rd[i] & 255];
    end
  end

  always @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (flush_req[i])
        rd[i] <= wr[i];
      else if (rst_i && pop_s[i]) begin
        rd[i]      <= rd[i] + 1;
        pop_cnt[i] <= pop_cnt[i] + 1;
      end
    end
  end

  // Accept pattern: 0 never, 1 every cycle, 2 every other cycle.
  int acc_mode = 1;
  always @(posedge clk_i) begin
    #1;
    if (acc_mode == 1)      tx_accept_i = 1'b1;
    else if (acc_mode == 2) tx_accept_i = ~tx_accept_i;
    else                    tx_accept_i = 1'b0;
  end

  // Monitor, sampling on the falling edge.
  int         start_cnt = 0, end_cnt = 0, nak_cnt = 0, stall_cnt = 0, multi_pop = 0;
  int         log_n = 0;
  logic [7:0] log_b [4096];
  logic       last_pid = 1'b0;

  always @(negedge clk_i) begin
    pop_s = fifo_pop_o;
    if (tx_start_o) begin
      start_cnt = start_cnt + 1;
      last_pid  = tx_data1_o;
    end
    if (tx_end_o)   end_cnt   = end_cnt + 1;
    if (tx_nak_o)   nak_cnt   = nak_cnt + 1;
    if (tx_stall_o) stall_cnt = stall_cnt + 1;
    if ($countones(fifo_pop_o) > 1) multi_pop = multi_pop + 1;
    if (tx_valid_o && tx_accept_i) begin
      log_b[log_n & 4095] = tx_data_o;
      log_n = log_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int ep, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      mem[ep][wr[ep] & 255] = 8'(base + k);
      wr[ep] = wr[ep] + 1;
    end
  endtask

  task automatic flush(input int ep);
    @(posedge clk_i); #1;
    flush_req = 4'(1 << ep);
    @(posedge clk_i); #1;
    flush_req = '0;
  endtask

  task automatic send_token(input int ep);
    @(posedge clk_i); #1;
    token_valid_i = 1'b1;
    token_ep_i    = 2'(ep);
    @(posedge clk_i); #1;
    token_valid_i = 1'b0;
  endtask

  int r_start, r_end, r_nak, r_stall, r_pid, r_bytes, r_first, r_last, r_pops_all;
  int r_pops [4];

  // One IN transaction; hs: 0 ACK, 1 timeout, 2 ACK with toggle_clr of the same endpoint.
  task automatic do_in(input int ep, input int hs);
    int  s_start, s_end, s_nak, s_stall, s_log;
    int  s_pop [4];
    bit  done, saw_end;
    s_start = start_cnt; s_end = end_cnt; s_nak = nak_cnt; s_stall = stall_cnt; s_log = log_n;
    for (int i = 0; i < 4; i++) s_pop[i] = pop_cnt[i];
    done = 1'b0; saw_end = 1'b0;
    send_token(ep);
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk_i);
      if (tx_end_o) begin
        saw_end = 1'b1;
        done    = 1'b1;
      end else if (!busy_o) begin
        done = 1'b1;
      end
    end
    if (!done) chk("in_budget_expired", 0, 1);
    if (saw_end) begin
      @(posedge clk_i); #1;
      rx_ack_i     = (hs != 1);
      rx_timeout_i = (hs == 1);
      toggle_clr_i = (hs == 2) ? 4'(1 << ep) : 4'h0;
      @(posedge clk_i); #1;
      rx_ack_i = 1'b0; rx_timeout_i = 1'b0; toggle_clr_i = '0;
    end
    @(posedge clk_i); #1;
    r_start = start_cnt - s_start;
    r_end   = end_cnt - s_end;
    r_nak   = nak_cnt - s_nak;
    r_stall = stall_cnt - s_stall;
    r_pid   = int'(last_pid);
    r_bytes = log_n - s_log;
    r_first = (r_bytes > 0) ? int'(log_b[s_log & 4095]) : -1;
    r_last  = (r_bytes > 0) ? int'(log_b[(log_n - 1) & 4095]) : -1;
    r_pops_all = 0;
    for (int i = 0; i < 4; i++) begin
      r_pops[i]  = pop_cnt[i] - s_pop[i];
      r_pops_all = r_pops_all + r_pops[i];
    end
  endtask

  typedef struct {
    int         ep;
    logic [3:0] stall;
    int         nbytes;
    int         exp_nak;
    int         exp_stall;
    int         exp_start;
    int         exp_pops;
  } vec_t;

  vec_t vt [5];

  initial begin
    int  got;
    int  s_log, s_pop2;
    vt[0] = '{ep: 1, stall: 4'b0000, nbytes: 0, exp_nak: 1, exp_stall: 0, exp_start: 0, exp_pops: 0};
    vt[1] = '{ep: 1, stall: 4'b0010, nbytes: 2, exp_nak: 0, exp_stall: 1, exp_start: 0, exp_pops: 0};
    vt[2] = '{ep: 3, stall: 4'b1000, nbytes: 0, exp_nak: 0, exp_stall: 1, exp_start: 0, exp_pops: 0};
    vt[3] = '{ep: 0, stall: 4'b0010, nbytes: 0, exp_nak: 1, exp_stall: 0, exp_start: 0, exp_pops: 0};
    vt[4] = '{ep: 1, stall: 4'b0001, nbytes: 2, exp_nak: 0, exp_stall: 0, exp_start: 1, exp_pops: 2};

    // Reset state
    #12;
    chk("reset_outputs", int'({fifo_pop_o, tx_valid_o, tx_data_o, tx_start_o, tx_data1_o,
                               tx_end_o, tx_nak_o, tx_stall_o, busy_o}), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("idle_busy", int'(busy_o), 0);

    // ep2: three bytes, ACK, then a DATA1 packet
    load(2, 3, 8'hA1);
    do_in(2, 0);
    chk("ep2_start", r_start, 1);
    chk("ep2_pid0", r_pid, 0);
    chk("ep2_bytes", r_bytes, 3);
    chk("ep2_byte0", int'(log_b[(log_n - 3) & 4095]), 8'hA1);
    chk("ep2_byte1", int'(log_b[(log_n - 2) & 4095]), 8'hA2);
    chk("ep2_byte2", int'(log_b[(log_n - 1) & 4095]), 8'hA3);
    chk("ep2_pops2", r_pops[2], 3);
    chk("ep2_pops_all", r_pops_all, 3);
    chk("ep2_end", r_end, 1);
    load(2, 1, 8'h55);
    do_in(2, 0);
    chk("ep2_pid1", r_pid, 1);
    chk("ep2_second_byte", r_first, 8'h55);

    // Table: RESP decisions
    for (int v = 0; v < 5; v++) begin
      ep_stall_i = vt[v].stall;
      load(vt[v].ep, vt[v].nbytes, 8'h30);
      do_in(vt[v].ep, 0);
      chk($sformatf("vec%0d_nak", v), r_nak, vt[v].exp_nak);
      chk($sformatf("vec%0d_stall", v), r_stall, vt[v].exp_stall);
      chk($sformatf("vec%0d_start", v), r_start, vt[v].exp_start);
      chk($sformatf("vec%0d_pops", v), r_pops_all, vt[v].exp_pops);
      ep_stall_i = '0;
      flush(vt[v].ep);
    end

    // NAK timing: two cycles after the token
    send_token(1);
    @(negedge clk_i);
    chk("nak_cycle1", int'(tx_nak_o), 0);
    @(negedge clk_i);
    chk("nak_cycle2", int'(tx_nak_o), 1);
    @(posedge clk_i); #1;

    // ep0: 100 bytes, accept every other cycle
    acc_mode = 2;
    load(0, 100, 0);
    do_in(0, 0);
    chk("ep0_p1_pops", r_pops[0], 64);
    chk("ep0_p1_end", r_end, 1);
    chk("ep0_p1_pid", r_pid, 0);
    chk("ep0_p1_last", r_last, 63);
    do_in(0, 0);
    chk("ep0_p2_pops", r_pops[0], 36);
    chk("ep0_p2_pid", r_pid, 1);
    chk("ep0_p2_first", r_first, 64);
    chk("ep0_p2_last", r_last, 99);
    acc_mode = 1;

    // ep3: timeout keeps toggle, clear beats ACK flip
    load(3, 10, 8'h70);
    do_in(3, 1);
    chk("ep3_p1_bytes", r_bytes, 10);
    chk("ep3_p1_pid", r_pid, 0);
    load(3, 2, 8'h80);
    do_in(3, 2);
    chk("ep3_after_timeout_pid", r_pid, 0);
    load(3, 1, 8'h90);
    do_in(3, 0);
    chk("ep3_after_clr_pid", r_pid, 0);

    // Reset mid-STREAM: ep2 first made DATA1
    load(2, 1, 8'h01);
    do_in(2, 0);
    load(2, 20, 8'h10);
    s_log  = log_n;
    s_pop2 = pop_cnt[2];
    send_token(2);
    got = 0;
    for (int k = 0; k < 200 && got == 0; k++) begin
      @(negedge clk_i); #1;
      if (log_n - s_log >= 5) got = 1;
    end
    chk("rst_wait_bytes", got, 1);
    chk("rst_pkt_pid", int'(last_pid), 1);
    rst_i = 1'b0;
    #1;
    chk("rst_mid_outputs", int'({fifo_pop_o, tx_valid_o, tx_data_o, tx_start_o, tx_data1_o,
                                 tx_end_o, tx_nak_o, tx_stall_o, busy_o}), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_pops", pop_cnt[2] - s_pop2, 4);
    do_in(2, 0);
    chk("rst_after_pid", r_pid, 0);
    chk("rst_after_bytes", r_bytes, 16);
    chk("rst_after_first", r_first, 8'h14);

    // Exactly MAX_PKT bytes then an empty FIFO
    load(0, 64, 8'hC0);
    do_in(0, 0);
    chk("zlp_full_bytes", r_bytes, 64);
    chk("zlp_full_pid", r_pid, 0);
    do_in(0, 0);
`ifdef USBF_TX_ZLP_EN
    chk("zlp_start", r_start, 1);
    chk("zlp_end", r_end, 1);
    chk("zlp_bytes", r_bytes, 0);
    chk("zlp_nak", r_nak, 0);
    chk("zlp_pid", r_pid, 1);
`else
    chk("nozlp_nak", r_nak, 1);
    chk("nozlp_start", r_start, 0);
`endif
    do_in(0, 0);
    chk("after_zlp_nak", r_nak, 1);
    chk("after_zlp_start", r_start, 0);

    chk("pop_onehot", multi_pop, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
